iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 25 ++
 rtl/iter_divider.sv | 167 ++++++++++++++++
 tb/tb_iter_divider.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
// State encoding and default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider.
// Purely combinational; the top owns all state.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH+1:0] shift;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  always_comb begin
    shift  = {rem_i, quo_i[WIDTH-1]};
    diff   = shift - {2'b00, dvs_i};
    borrow = diff[WIDTH+1];
    rem_o  = borrow ? shift[WIDTH:0] : diff[WIDTH:0];
    quo_o  = {quo_i[WIDTH-2:0], ~borrow};
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// Define ITER_DIVIDER_SIGNED_EN for two's complement operands.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

`ifdef ITER_DIVIDER_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  function automatic logic [WIDTH-1:0] mag(
    input logic [WIDTH-1:0] x
  );
    return x[WIDTH-1] ? -x : x;
  endfunction
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    zero_d      = zero_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef ITER_DIVIDER_SIGNED_EN
    negq_d      = negq_q;
    negr_d      = negr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dbz_d  = 1'b0;
          cnt_d  = '0;
          zero_d = (divisor == '0);
          if (divisor == '0) begin
            // Zero-divisor result is staged in the work regs
            quo_d   = '1;
            rem_d   = {1'b0, dividend};
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
`ifdef ITER_DIVIDER_SIGNED_EN
            quo_d   = mag(dividend);
            dvs_d   = mag(divisor);
            negq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            negr_d  = dividend[WIDTH-1];
`else
            quo_d   = dividend;
            dvs_d   = divisor;
`endif
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        busy_d = 1'b1;
        rem_d  = step_rem;
        quo_d  = step_quo;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        dbz_d       = zero_q;
        state_d     = S_IDLE;
        quotient_d  = quo_q;
        remainder_d = rem_q[WIDTH-1:0];
`ifdef ITER_DIVIDER_SIGNED_EN
        if (!zero_q) begin
          quotient_d  = negq_q ? -quo_q : quo_q;
          remainder_d = negr_q ? -rem_q[WIDTH-1:0]
                               : rem_q[WIDTH-1:0];
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef ITER_DIVIDER_SIGNED_EN
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef ITER_DIVIDER_SIGNED_EN
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider (WIDTH=8).
// Random operations are checked against an arithmetic reference model.
module tb_iter_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;
  int k = 0;

  iter_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic void ref_div(
    input  logic [7:0] a, b,
    output logic [7:0] q, r,
    output logic       z
  );
    int sa, sb;
    z = (b == 0);
    if (b == 0) begin
      q = 8'hFF;
      r = a;
    end else begin
`ifdef ITER_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sa == -128 && sb == -1) begin
        q = 8'h80;
        r = 8'h00;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
`else
      sa = int'(a);
      sb = int'(b);
      q = 8'(sa / sb);
      r = 8'(sa % sb);
`endif
    end
  endfunction

  task automatic launch(input logic [7:0] a, b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = edge_cnt;
  endtask

  task automatic wait_done(output int lat, output int nbusy);
    lat = -1;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (busy) nbusy++;
      if (done) begin
        lat = edge_cnt - k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
    end
    checks++;
    if ({quotient, remainder} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h want 0000", {quotient, remainder});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, nb;
    logic [7:0] eq, er;
`ifdef ITER_DIVIDER_SIGNED_EN
    eq = 8'hF8;
    er = 8'h00;
`else
    eq = 8'd28;
    er = 8'd4;
`endif
    launch(8'd200, 8'd7);
    wait_done(lat, nb);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d want 9", lat);
    end
    checks++;
    if (nb !== 8) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d want 8", nb);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {eq, er, 1'b0}) begin
      errors++;
      $display("FAIL basic_result: got q=%0d r=%0d z=%b want q=%0d r=%0d z=0",
               quotient, remainder, div_by_zero, eq, er);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_single_pulse: got done=%b want 0", done);
    end
  endtask

  task automatic test_div_zero;
    int lat, nb;
    launch(8'd13, 8'd0);
    wait_done(lat, nb);
    checks++;
    if (lat !== 1 || nb !== 0) begin
      errors++;
      $display("FAIL zero_latency: got lat=%0d busy=%0d want 1/0", lat, nb);
    end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {8'd255, 8'd13, 1'b1}) begin
      errors++;
      $display("FAIL zero_result: got q=%0d r=%0d z=%b want 255 13 1",
               quotient, remainder, div_by_zero);
    end
    launch(8'd255, 8'd1);
    checks++;
    if (div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL zero_clear: got z=%b want 0", div_by_zero);
    end
    wait_done(lat, nb);
    checks++;
    if (lat !== 9 || {quotient, remainder, div_by_zero} !== {8'd255, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL zero_next: got lat=%0d q=%0d r=%0d z=%b want 9 255 0 0",
               lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_ignore_start;
    int lat, nb;
    launch(8'd100, 8'd9);
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd250;
    divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, nb);
    checks++;
    if (lat !== 9 || {quotient, remainder} !== {8'd11, 8'd1}) begin
      errors++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d want 9 11 1",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_reset_mid;
    int lat, nb, ndone;
    launch(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div_by_zero, quotient, remainder} !== 19'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h want 0",
               {busy, done, div_by_zero, quotient, remainder});
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d pulses want 0", ndone);
    end
    launch(8'd50, 8'd5);
    wait_done(lat, nb);
    checks++;
    if (lat !== 9 || {quotient, remainder} !== {8'd10, 8'd0}) begin
      errors++;
      $display("FAIL midreset_next: got lat=%0d q=%0d r=%0d want 9 10 0",
               lat, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb, k1;
    launch(8'd3, 8'd5);
    k1 = k;
    wait_done(lat, nb);
    checks++;
    if (lat !== 9 || {quotient, remainder} !== {8'd0, 8'd3}) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want 9 0 3",
               lat, quotient, remainder);
    end
    launch(8'd0, 8'd5);
    checks++;
    if (k - k1 !== 10) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d want 10", k - k1);
    end
    wait_done(lat, nb);
    checks++;
    if (lat !== 9 || {quotient, remainder} !== {8'd0, 8'd0}) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want 9 0 0",
               lat, quotient, remainder);
    end
  endtask

`ifdef ITER_DIVIDER_SIGNED_EN
  task automatic test_signed;
    int lat, nb;
    launch(8'h9C, 8'd7);
    wait_done(lat, nb);
    checks++;
    if (lat !== 9 || {quotient, remainder} !== {8'hF2, 8'hFE}) begin
      errors++;
      $display("FAIL signed_neg100_7: got lat=%0d q=%h r=%h want 9 f2 fe",
               lat, quotient, remainder);
    end
    launch(8'h80, 8'hFF);
    wait_done(lat, nb);
    checks++;
    if (lat !== 9 || {quotient, remainder} !== {8'h80, 8'h00}) begin
      errors++;
      $display("FAIL signed_min_neg1: got lat=%0d q=%h r=%h want 9 80 00",
               lat, quotient, remainder);
    end
  endtask
`endif

  task automatic test_random;
    int lat, nb, elat;
    logic [7:0] a, b, eq, er;
    logic ez;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      ref_div(a, b, eq, er, ez);
      elat = ez ? 1 : 9;
      launch(a, b);
      wait_done(lat, nb);
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL rand_latency %0d/%0d: got %0d want %0d", a, b, lat, elat);
      end
      checks++;
      if ({quotient, remainder, div_by_zero} !== {eq, er, ez}) begin
        errors++;
        $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                 a, b, quotient, remainder, div_by_zero, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef ITER_DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
